// File: rtl/relay_nibble_scheduler_if.sv
// Nibble sources, mode request and relay-datapath outputs of the relay nibble scheduler.
interface relay_nibble_scheduler_if;
    logic [2:0] mode_cfg;
    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] data_out;
    logic       data_out_available;
    logic [2:0] hi_simulate_mod_type;
    logic [1:0] grant;
    logic       timeout_pulse;
    logic [7:0] drop_count;

    modport master (
        output mode_cfg, a_data, a_valid, b_data, b_valid,
        input  a_ready, b_ready, data_out, data_out_available,
               hi_simulate_mod_type, grant, timeout_pulse, drop_count
    );

    modport slave (
        input  mode_cfg, a_data, a_valid, b_data, b_valid,
        output a_ready, b_ready, data_out, data_out_available,
               hi_simulate_mod_type, grant, timeout_pulse, drop_count
    );
endinterface

// File: rtl/relay_nibble_scheduler.sv
// Buffers two nibble sources, arbitrates whole frames round-robin and paces nibbles
// out to the relay datapath at its shift rate.
module relay_nibble_scheduler #(
    parameter int NIBBLE_PERIOD = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int FRAME_TIMEOUT = 1024
) (
    input logic                    clk,
    input logic                    rst_n,
    relay_nibble_scheduler_if.slave bus
);
    localparam int PW = $clog2(NIBBLE_PERIOD);
    localparam int GW = $clog2(2 * NIBBLE_PERIOD);
    localparam int TW = $clog2(FRAME_TIMEOUT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] MODE_READER = 3'b101;
    localparam logic [2:0] MODE_TAG    = 3'b110;

    typedef enum logic [1:0] {IDLE, LOCKED, FLUSH, GAP} state_t;

    state_t state_q, state_d;

    logic [PW-1:0] paceCnt_q, paceCnt_d;
    logic [3:0]    dataOut_q, dataOut_d;
    logic          avail_q, avail_d;
    logic          timeout_q, timeout_d;
    logic [2:0]    modType_q, modType_d;
    logic [7:0]    dropCount_q, dropCount_d;
    logic [1:0]    grant_q, grant_d;
    logic          ownerB_q, ownerB_d;
    logic          lastB_q, lastB_d;
    logic [1:0]    zeroRun_q, zeroRun_d;
    logic [TW-1:0] emptyRun_q, emptyRun_d;
    logic          flushCnt_q, flushCnt_d;
    logic [GW-1:0] gapCnt_q, gapCnt_d;

    logic [1:0][FIFO_DEPTH-1:0][3:0] fifoMem_q;
    logic [1:0][AW-1:0]              wrPtr_q, rdPtr_q;
    logic [1:0][CW-1:0]              count_q;

    logic [1:0][3:0] srcData, head;
    logic [1:0]      srcValid, ready, push, pop, empty, full;
    logic            modeEnabled, modePending, selB, grantedEmpty;
    logic [3:0]      startChar, selHead, grantedHead, issueData;
    logic            idleAct, idleStart, lockIssue, timeoutHit, flushIssue;
    logic            flushEnd, zeroEnd, gapDone, issue;

    assign srcData  = {bus.b_data, bus.a_data};
    assign srcValid = {bus.b_valid, bus.a_valid};

    for (genvar s = 0; s < 2; s++) begin : g_fifoStatus
        assign head[s]  = fifoMem_q[s][rdPtr_q[s]];
        assign empty[s] = (count_q[s] == '0);
        assign full[s]  = (count_q[s] == CW'(FIFO_DEPTH));
    end

    // A pending mode change in IDLE flushes both FIFOs, so writes are held off that cycle.
    assign modeEnabled = (modType_q == MODE_READER) || (modType_q == MODE_TAG);
    assign modePending = (state_q == IDLE) && (bus.mode_cfg != modType_q);
    assign ready       = {2{modeEnabled && !modePending}} & ~full;
    assign push        = srcValid & ready;

    assign startChar    = (modType_q == MODE_TAG) ? 4'hF : 4'hC;
    assign selB         = (empty == 2'b00) ? !lastB_q : empty[0];
    assign selHead      = head[selB];
    assign grantedEmpty = empty[ownerB_q];
    assign grantedHead  = head[ownerB_q];

    assign idleAct    = (state_q == IDLE) && !modePending && modeEnabled
                        && (paceCnt_q == '0) && (empty != 2'b11);
    assign idleStart  = idleAct && (selHead == startChar);
    assign lockIssue  = (state_q == LOCKED) && (paceCnt_q == '0) && !grantedEmpty;
    assign timeoutHit = (state_q == LOCKED) && grantedEmpty
                        && (emptyRun_q == TW'(FRAME_TIMEOUT - 1));
    assign zeroEnd    = lockIssue && (grantedHead == 4'h0) && (zeroRun_q == 2'd1);
    assign flushIssue = (state_q == FLUSH) && (paceCnt_q == '0);
    assign flushEnd   = flushIssue && flushCnt_q;
    assign gapDone    = (state_q == GAP) && (gapCnt_q == GW'(2 * NIBBLE_PERIOD - 1));

    assign pop[0] = (idleAct && !selB) || (lockIssue && !ownerB_q);
    assign pop[1] = (idleAct && selB)  || (lockIssue && ownerB_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            paceCnt_q   <= '0;
            dataOut_q   <= '0;
            avail_q     <= 1'b0;
            timeout_q   <= 1'b0;
            modType_q   <= '0;
            dropCount_q <= '0;
            grant_q     <= '0;
            ownerB_q    <= 1'b0;
            lastB_q     <= 1'b1;
            zeroRun_q   <= '0;
            emptyRun_q  <= '0;
            flushCnt_q  <= 1'b0;
            gapCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            paceCnt_q   <= paceCnt_d;
            dataOut_q   <= dataOut_d;
            avail_q     <= avail_d;
            timeout_q   <= timeout_d;
            modType_q   <= modType_d;
            dropCount_q <= dropCount_d;
            grant_q     <= grant_d;
            ownerB_q    <= ownerB_d;
            lastB_q     <= lastB_d;
            zeroRun_q   <= zeroRun_d;
            emptyRun_q  <= emptyRun_d;
            flushCnt_q  <= flushCnt_d;
            gapCnt_q    <= gapCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (idleStart) state_d = LOCKED;
            LOCKED: begin
                if (timeoutHit)   state_d = FLUSH;
                else if (zeroEnd) state_d = GAP;
            end
            FLUSH:   if (flushEnd) state_d = GAP;
            GAP:     if (gapDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue     = idleStart || lockIssue || flushIssue;
        issueData = flushIssue ? 4'h0 : (idleStart ? selHead : grantedHead);
        paceCnt_d = issue ? PW'(NIBBLE_PERIOD - 1)
                          : ((paceCnt_q != '0) ? paceCnt_q - PW'(1) : paceCnt_q);
        dataOut_d = issue ? issueData : dataOut_q;
        avail_d   = issue;
        timeout_d = timeoutHit;
        modType_d = modePending ? bus.mode_cfg : modType_q;

        dropCount_d = dropCount_q;
        if (idleAct && !idleStart && (dropCount_q != 8'hFF))
            dropCount_d = dropCount_q + 8'd1;

        grant_d    = grant_q;
        ownerB_d   = ownerB_q;
        lastB_d    = lastB_q;
        zeroRun_d  = zeroRun_q;
        emptyRun_d = emptyRun_q;
        flushCnt_d = flushCnt_q;
        gapCnt_d   = (state_q == GAP) ? gapCnt_q + GW'(1) : '0;

        if (idleStart) begin
            grant_d    = selB ? 2'b10 : 2'b01;
            ownerB_d   = selB;
            zeroRun_d  = '0;
            emptyRun_d = '0;
        end
        if (state_q == LOCKED)
            emptyRun_d = grantedEmpty ? emptyRun_q + TW'(1) : '0;
        if (lockIssue)
            zeroRun_d = (grantedHead == 4'h0) ? zeroRun_q + 2'd1 : 2'd0;
        if (timeoutHit)
            flushCnt_d = 1'b0;
        if (flushIssue)
            flushCnt_d = 1'b1;
        if (gapDone) begin
            grant_d = '0;
            lastB_d = ownerB_q;
        end
    end

    // Same-cycle push and pop on one FIFO leave its count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n || modePending) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wrPtr_q[s] <= wrPtr_q[s] + AW'(1);
                if (pop[s])  rdPtr_q[s] <= rdPtr_q[s] + AW'(1);
                count_q[s] <= count_q[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) fifoMem_q[s][wrPtr_q[s]] <= srcData[s];
        end
    end

    assign bus.a_ready              = ready[0];
    assign bus.b_ready              = ready[1];
    assign bus.data_out             = dataOut_q;
    assign bus.data_out_available   = avail_q;
    assign bus.hi_simulate_mod_type = modType_q;
    assign bus.grant                = grant_q;
    assign bus.timeout_pulse        = timeout_q;
    assign bus.drop_count           = dropCount_q;
endmodule

// File: tb/tb_relay_nibble_scheduler.sv
// Randomized bench for relay_nibble_scheduler, compared cycle by cycle against a
// queue-based behavioural model of the frame scheduling rules.
module tb_relay_nibble_scheduler;
    localparam int NP    = 64;
    localparam int DEPTH = 4;
    localparam int TMO   = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    relay_nibble_scheduler_if bus();

    relay_nibble_scheduler #(
        .NIBBLE_PERIOD(NP),
        .FIFO_DEPTH(DEPTH),
        .FRAME_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checkCount = 0;
    int passCount  = 0;
    int validPct   = 100;

    string      phase;
    logic [2:0] mMode;
    logic [3:0] qA[$], qB[$], pendA[$], pendB[$];
    int         pace, zeros, emptyRun, flushLeft, gapLeft, owner, lastServed, drops;
    logic [3:0] mData;
    bit         mStrobe, mTimeout, expReadyA, expReadyB;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit modeOn(input logic [2:0] m);
        return (m == 3'b101) || (m == 3'b110);
    endfunction

    function automatic bit modelReady(input int size);
        return modeOn(mMode) && (size < DEPTH) && !(phase == "IDLE" && bus.mode_cfg != mMode);
    endfunction

    task automatic modelReset();
        phase = "IDLE";
        mMode = 3'b000;
        qA.delete();
        qB.delete();
        pace = 0; zeros = 0; emptyRun = 0; flushLeft = 0; gapLeft = 0;
        owner = -1; lastServed = 1; drops = 0;
        mData = 4'h0; mStrobe = 0; mTimeout = 0;
    endtask

    // One clock of the scheduler, evaluated on pre-edge inputs and queue contents.
    task automatic modelStep();
        bit wrA, wrB, issued;
        logic [3:0] d, hd, start;
        int src, sz;
        wrA = bus.a_valid && expReadyA;
        wrB = bus.b_valid && expReadyB;
        issued = 0; d = 4'h0; mTimeout = 0;
        start = (mMode == 3'b110) ? 4'hF : 4'hC;
        if (phase == "IDLE") begin
            if (bus.mode_cfg != mMode) begin
                mMode = bus.mode_cfg;
                qA.delete();
                qB.delete();
            end else if (modeOn(mMode) && pace == 0 && (qA.size() > 0 || qB.size() > 0)) begin
                if (qA.size() > 0 && qB.size() > 0) src = 1 - lastServed;
                else src = (qA.size() > 0) ? 0 : 1;
                if (src == 0) hd = qA.pop_front();
                else hd = qB.pop_front();
                if (hd == start) begin
                    issued = 1; d = hd; owner = src; phase = "LOCKED"; zeros = 0; emptyRun = 0;
                end else if (drops < 255) begin
                    drops++;
                end
            end
        end else if (phase == "LOCKED") begin
            sz = (owner == 0) ? qA.size() : qB.size();
            if (sz == 0) begin
                emptyRun++;
                if (emptyRun == TMO) begin
                    mTimeout = 1; phase = "FLUSH"; flushLeft = 2;
                end
            end else begin
                emptyRun = 0;
                if (pace == 0) begin
                    if (owner == 0) d = qA.pop_front();
                    else d = qB.pop_front();
                    issued = 1;
                    zeros = (d == 4'h0) ? zeros + 1 : 0;
                    if (zeros == 2) begin
                        phase = "GAP"; gapLeft = 2 * NP;
                    end
                end
            end
        end else if (phase == "FLUSH") begin
            if (pace == 0) begin
                issued = 1; d = 4'h0; flushLeft--;
                if (flushLeft == 0) begin
                    phase = "GAP"; gapLeft = 2 * NP;
                end
            end
        end else begin
            gapLeft--;
            if (gapLeft == 0) begin
                lastServed = owner; owner = -1; phase = "IDLE";
            end
        end
        mStrobe = issued;
        if (issued) begin
            mData = d; pace = NP - 1;
        end else if (pace > 0) begin
            pace--;
        end
        if (wrA) qA.push_back(bus.a_data);
        if (wrB) qB.push_back(bus.b_data);
    endtask

    task automatic tick();
        logic [1:0] expGrant;
        #1;
        expReadyA = modelReady(qA.size());
        expReadyB = modelReady(qB.size());
        checkOutput("a_ready", bus.a_ready, expReadyA);
        checkOutput("b_ready", bus.b_ready, expReadyB);
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else begin
            modelStep();
            if (bus.a_valid && expReadyA) void'(pendA.pop_front());
            if (bus.b_valid && expReadyB) void'(pendB.pop_front());
        end
        #1;
        expGrant = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
        checkOutput("strobe", bus.data_out_available, mStrobe);
        checkOutput("data_out", bus.data_out, mData);
        checkOutput("mode", bus.hi_simulate_mod_type, mMode);
        checkOutput("grant", bus.grant, expGrant);
        checkOutput("timeout", bus.timeout_pulse, mTimeout);
        checkOutput("drop_count", bus.drop_count, drops);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.a_valid = (pendA.size() > 0) && ($urandom_range(1, 100) <= validPct);
            bus.a_data  = bus.a_valid ? pendA[0] : 4'($urandom);
            bus.b_valid = (pendB.size() > 0) && ($urandom_range(1, 100) <= validPct);
            bus.b_data  = bus.b_valid ? pendB[0] : 4'($urandom);
            tick();
        end
    endtask

    task automatic pushNib(input int src, input logic [3:0] n);
        if (src == 0) pendA.push_back(n);
        else pendB.push_back(n);
    endtask

    task automatic pushFrame(input int src, input logic [3:0] start, input int bodyLen);
        logic [3:0] n;
        bit prevZero;
        prevZero = 0;
        pushNib(src, start);
        for (int i = 0; i < bodyLen; i++) begin
            n = 4'($urandom_range(0, 15));
            if ((prevZero || i == bodyLen - 1) && n == 4'h0) n = 4'h1;
            prevZero = (n == 4'h0);
            pushNib(src, n);
        end
        pushNib(src, 4'h0);
        pushNib(src, 4'h0);
    endtask

    task automatic pushJunk(input int src, input int cnt, input logic [3:0] start);
        logic [3:0] n;
        for (int i = 0; i < cnt; i++) begin
            n = 4'($urandom_range(0, 15));
            if (n == start) n = start ^ 4'h1;
            pushNib(src, n);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!(pendA.size() == 0 && pendB.size() == 0 && qA.size() == 0 && qB.size() == 0
                 && phase == "IDLE") && n < limit) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("drain_bound", 32'(n < limit), 1);
    endtask

    initial begin
        int n;
        logic [2:0] m;
        logic [3:0] st;
        bus.mode_cfg = 3'b110;
        bus.a_valid = 1'b0; bus.a_data = 4'h0;
        bus.b_valid = 1'b0; bus.b_data = 4'h0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        $display("[TB] both sources hold an F frame at reset release");
        pendA = '{4'hF, 4'h1, 4'h0, 4'h0};
        pendB = '{4'hF, 4'h1, 4'h0, 4'h0};
        drain(3000);

        $display("[TB] fake reader, A sends C,3,2,0,0");
        bus.mode_cfg = 3'b101;
        pendA = '{4'hC, 4'h3, 4'h2, 4'h0, 4'h0};
        drain(3000);

        $display("[TB] B sends junk before its start char");
        pendB = '{4'h5, 4'h7, 4'hC, 4'h9, 4'h0, 4'h0};
        drain(3000);

        $display("[TB] fake tag, A stalls mid frame");
        bus.mode_cfg = 3'b110;
        pendA = '{4'hF, 4'h1};
        drain(TMO + 800);

        $display("[TB] mode change mid frame and back-to-back writes");
        bus.mode_cfg = 3'b101;
        pushFrame(0, 4'hC, 6);
        applyStimulus(200);
        bus.mode_cfg = 3'b110;
        drain(3000);
        pushFrame(1, 4'hF, 2);
        drain(3000);

        $display("[TB] disabled mode refuses writes");
        bus.mode_cfg = 3'b000;
        pushJunk(0, 3, 4'hC);
        pushFrame(1, 4'hC, 1);
        applyStimulus(100);
        pendA.delete();
        pendB.delete();

        $display("[TB] reset while locked");
        bus.mode_cfg = 3'b101;
        pushFrame(0, 4'hC, 5);
        n = 0;
        while (phase != "LOCKED" && n < 500) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("lock_bound", 32'(n < 500), 1);
        applyStimulus(70);
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        pendA.delete();
        pendB.delete();
        pushFrame(0, 4'hC, 2);
        drain(3000);

        $display("[TB] drop counter saturation");
        pushJunk(0, 150, 4'hC);
        pushJunk(1, 150, 4'hC);
        drain(2000);

        $display("[TB] randomized frames");
        for (int it = 0; it < 12; it++) begin
            m = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b110;
            st = (m == 3'b110) ? 4'hF : 4'hC;
            bus.mode_cfg = m;
            validPct = $urandom_range(30, 100);
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 2) != 0) pushJunk(s, $urandom_range(0, 2), st);
                if ($urandom_range(0, 3) != 0) pushFrame(s, st, $urandom_range(1, 4));
            end
            drain(8000);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/relay_nibble_scheduler.md
Name: relay_nibble_scheduler

Overview:
- Feeds the relay-mode datapath from two nibble sources: A = ARM/SSP path, B = local demodulator.
- Buffers each source in a small FIFO and paces nibbles to the relay datapath's shift rate.
- Arbitrates round-robin at frame granularity: a frame, once started, owns the datapath until it ends.
- Latches the relay operating mode (fake reader / fake tag) and presents it to the relay datapath.

Parameters:
- NIBBLE_PERIOD, 64: minimum clocks between output nibbles; 4 bits at 16 clk/bit.
- FIFO_DEPTH, 4: entries per source FIFO; power of two, at least 2.
- FRAME_TIMEOUT, 1024: consecutive clocks with an empty granted FIFO before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode_cfg  in  3  requested mode: 3'b101 FAKE_READER, 3'b110 FAKE_TAG; any other value = disabled.
- a_data  in  4  source A nibble.
- a_valid  in  1  source A nibble valid.
- a_ready  out  1  source A FIFO can accept.
- b_data  in  4  source B nibble.
- b_valid  in  1  source B nibble valid.
- b_ready  out  1  source B FIFO can accept.
- data_out  out  4  nibble to the relay datapath data input.
- data_out_available  out  1  single-cycle strobe qualifying data_out.
- hi_simulate_mod_type  out  3  latched mode to the relay datapath.
- grant  out  2  one-hot owner of the current frame (bit0 = A, bit1 = B); 0 when no frame is open.
- timeout_pulse  out  1  one-cycle pulse when a frame is aborted.
- drop_count  out  8  saturating count of discarded out-of-frame nibbles.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All outputs go to 0 and both FIFOs empty.
  - State = IDLE, pace counter = 0, round-robin pointer favours A.
  - Applies identically mid-frame.
- Mode latch: hi_simulate_mod_type <= mode_cfg only in IDLE, one cycle after any difference is seen. Both FIFOs are flushed on that same cycle.
- Mode changes in any other state are deferred until IDLE is re-entered.
- Disabled mode:
  - a_ready = b_ready = 0 and nothing is issued.
  - An open frame still completes under the previously latched mode.
- FIFO write: x_ready = !full && mode enabled; an entry is written when x_valid && x_ready. Full FIFO: x_ready = 0 and the producer holds.
- Pacing:
  - An issue may occur only when pace_cnt == 0.
  - Each issue reloads pace_cnt to NIBBLE_PERIOD-1, then it decrements to 0 and saturates.
  - An issue drives data_out = FIFO head and pulses data_out_available for one clk.
- Start char: 4'hC in FAKE_READER, 4'hF in FAKE_TAG.
- State IDLE:
  - Acts when pace_cnt == 0 and at least one FIFO is non-empty.
  - Selects a source: the non-empty one; if both are non-empty, the source not served last.
  - Pops the selected head.
  - Head == start char: issue it, set grant, go to LOCKED, zero-run = 0.
  - Otherwise: discard with no strobe, increment drop_count (saturates at 255), stay in IDLE. A drop does not consume pacing.
- State LOCKED:
  - Only the granted FIFO is popped, one nibble per paced issue; the other FIFO keeps filling.
  - Issued nibble == 0: zero-run increments. Nonzero: zero-run clears.
  - Zero-run reaches 2: go to GAP; grant is held through GAP.
  - Granted FIFO empty for FRAME_TIMEOUT consecutive clocks: pulse timeout_pulse and go to FLUSH.
- State FLUSH: issue two paced 4'h0 nibbles (not from the FIFO) so the relay datapath returns to listen, then go to GAP.
- State GAP:
  - Wait 2*NIBBLE_PERIOD clocks.
  - Record the served source as last-served, clear grant, go to IDLE.
- Latency:
  - FIFO write to strobe is 2 clk minimum: 1 clk write, 1 clk registered output, when pace_cnt == 0 and state allows.
  - Output strobes are never closer than NIBBLE_PERIOD clocks apart.
- Simultaneous write and pop on the same FIFO are both honoured; count is unchanged.

Test Plan:
- FAKE_READER, A sends C,3,2,0,0 → five strobes 64 clk apart, data C,3,2,0,0. grant = 01 from the first strobe through GAP, then 00 after 128 clk.
- FAKE_TAG, A and B each hold F,1,0,0 at reset release → A's frame issues first and completes. B's frame starts after GAP with grant = 10; no interleaving.
- FAKE_READER, B sends 5,7 then C → 5 and 7 dropped (drop_count = 2, no strobe), then C issued with grant = 10.
- FAKE_TAG, A sends F,1 then stalls → after 1024 idle clk timeout_pulse fires, then two strobes with data 0, then IDLE.
- mode_cfg changes from 101 to 110 mid-frame → hi_simulate_mod_type stays 101 until the frame ends, then updates to 110 and both FIFOs flush. Also: 4 back-to-back writes → a_ready = 0 until the first pop.
- rst_n low for 1 clk while LOCKED → next cycle all outputs 0, FIFOs empty, and a new C frame is accepted normally.
